// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the fetch sequencer: FSM states, instruction
// field positions and opcode values.
package fetch_sequencer_pkg;

  localparam int OP_W    = 4;
  localparam int INSTR_W = 16;
  localparam int OPC_HI  = 15;
  localparam int OPC_LO  = 12;
  localparam int TGT_W   = 12;
  localparam int OFF_W   = 6;

  localparam logic [OP_W-1:0] OPC_ALU  = 4'h0;
  localparam logic [OP_W-1:0] OPC_ADDI = 4'h1;
  localparam logic [OP_W-1:0] OPC_LW   = 4'h2;
  localparam logic [OP_W-1:0] OPC_SW   = 4'h3;
  localparam logic [OP_W-1:0] OPC_BEQ  = 4'h4;
  localparam logic [OP_W-1:0] OPC_BNE  = 4'h5;
  localparam logic [OP_W-1:0] OPC_J    = 4'h6;
  localparam logic [OP_W-1:0] OPC_JAL  = 4'h7;
  localparam logic [OP_W-1:0] OPC_JR   = 4'h8;
  localparam logic [OP_W-1:0] OPC_HLT  = 4'hF;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_t;

  function automatic logic [OP_W-1:0] opcode_of(input logic [INSTR_W-1:0] word);
    return word[OPC_HI:OPC_LO];
  endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: priority mux over halt, register jump,
// absolute jump, taken branch and sequential increment.
module next_pc_calc
  import fetch_sequencer_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic [ADDR_W-1:0]  pc,
  input  logic [INSTR_W-1:0] instr,
  input  logic               hlt,
  input  logic               jr,
  input  logic               jmp,
  input  logic               jal,
  input  logic               br_eq,
  input  logic               br_ne,
  input  logic               zero,
  input  logic [ADDR_W-1:0]  jr_target,
  output logic [ADDR_W-1:0]  pc1,
  output logic [ADDR_W-1:0]  next_pc
);

  logic [ADDR_W-1:0] jump_pc;
  logic [ADDR_W-1:0] branch_pc;
  logic              taken;

  assign pc1       = pc + ADDR_W'(1);
  assign jump_pc   = {pc1[ADDR_W-1:TGT_W], instr[TGT_W-1:0]};
  assign branch_pc = pc1 + {{(ADDR_W-OFF_W){instr[OFF_W-1]}}, instr[OFF_W-1:0]};
  assign taken     = (br_eq & zero) | (br_ne & ~zero);

  // Overlapping flags are legal; the first match in this chain wins.
  always_comb begin
    next_pc = pc1;
    if (hlt)
      next_pc = pc;
    else if (jr)
      next_pc = jr_target;
    else if (jmp | jal)
      next_pc = jump_pc;
    else if (taken)
      next_pc = branch_pc;
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch / program-flow stage: FETCH -> EXEC -> FETCH loop, HALT until reset.
// Optional FETCH_PERF_CNT_EN adds saturating retired/stall counters.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic [OP_W-1:0]    op_code,
  output logic               instr_valid,
  input  logic               stall,
  input  logic               br_eq,
  input  logic               br_ne,
  input  logic               jmp,
  input  logic               jal,
  input  logic               jr,
  input  logic               hlt,
  input  logic               zero,
  input  logic [ADDR_W-1:0]  jr_target,
  output logic [ADDR_W-1:0]  pc_link,
  output logic               halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        retired_cnt,
  output logic [31:0]        stall_cnt
`endif
);

  fetch_state_t      state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc1;
  logic [ADDR_W-1:0] next_pc;

  next_pc_calc #(.ADDR_W(ADDR_W)) u_next_pc (
    .pc        (pc),
    .instr     (instr),
    .hlt       (hlt),
    .jr        (jr),
    .jmp       (jmp),
    .jal       (jal),
    .br_eq     (br_eq),
    .br_ne     (br_ne),
    .zero      (zero),
    .jr_target (jr_target),
    .pc1       (pc1),
    .next_pc   (next_pc)
  );

  // Request drops in the reset cycle itself so a late ready is never accepted.
  assign imem_req  = (state == ST_FETCH) & ~rst;
  assign imem_addr = pc;
  assign op_code   = opcode_of(instr);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_FETCH;
      pc          <= RESET_PC;
      instr       <= '0;
      instr_valid <= 1'b0;
      pc_link     <= '0;
      halted      <= 1'b0;
    end else begin
      case (state)
        ST_FETCH: begin
          if (imem_ready) begin
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
            state       <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (!stall) begin
            instr_valid <= 1'b0;
            if (jal)
              pc_link <= pc1;
            if (hlt) begin
              state  <= ST_HALT;
              halted <= 1'b1;
            end else begin
              pc    <= next_pc;
              state <= ST_FETCH;
            end
          end
        end
        ST_HALT: begin
        end
        default: state <= ST_FETCH;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Both counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      retired_cnt <= '0;
      stall_cnt   <= '0;
    end else if (state == ST_EXEC) begin
      if (stall) begin
        if (stall_cnt != '1)
          stall_cnt <= stall_cnt + 32'd1;
      end else if (retired_cnt != '1) begin
        retired_cnt <= retired_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized scoreboard bench for fetch_sequencer: stimulus pushes expectations
// from an arithmetic reference model, a negedge monitor pops and compares.
module tb_fetch_sequencer;
  import fetch_sequencer_pkg::*;

  localparam int          ADDR_W   = 16;
  localparam logic [15:0] RESET_PC = 16'h0000;

  typedef struct packed {
    logic hlt;
    logic jr;
    logic jmp;
    logic jal;
    logic beq;
    logic bne;
    logic zero;
  } flags_t;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] link;
    logic [15:0] instr;
  } fetch_exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [15:0] imem_rdata = 16'h0;
  logic [15:0] instr;
  logic [3:0]  op_code;
  logic        instr_valid;
  logic        stall = 1'b0;
  logic        br_eq = 1'b0, br_ne = 1'b0, jmp = 1'b0, jal = 1'b0, jr = 1'b0, hlt = 1'b0, zero = 1'b0;
  logic [15:0] jr_target = 16'h0;
  logic [15:0] pc_link;
  logic        halted;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] retired_cnt;
  logic [31:0] stall_cnt;
`endif

  fetch_sequencer #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .op_code     (op_code),
    .instr_valid (instr_valid),
    .stall       (stall),
    .br_eq       (br_eq),
    .br_ne       (br_ne),
    .jmp         (jmp),
    .jal         (jal),
    .jr          (jr),
    .hlt         (hlt),
    .zero        (zero),
    .jr_target   (jr_target),
    .pc_link     (pc_link),
    .halted      (halted)
`ifdef FETCH_PERF_CNT_EN
    ,
    .retired_cnt (retired_cnt),
    .stall_cnt   (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  fetch_exp_t  fetch_q[$];
  logic [15:0] instr_q[$];
  logic [15:0] halt_q[$];
  int          vectors = 0;
  int          errors  = 0;

  logic [15:0] m_pc   = RESET_PC;
  logic [15:0] m_link = 16'h0;
  logic [15:0] m_last = 16'h0;
  int          m_retired = 0;
  int          m_stalls  = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic reportFail(input string name);
    vectors++;
    errors++;
    $display("[TB] FAIL %s: got no event, expected one at %0t", name, $time);
  endtask

  // Reference model: next address from the flow rules using plain integer arithmetic.
  function automatic logic [15:0] modelNext(input logic [15:0] pc, input logic [15:0] word,
                                            input flags_t f, input logic [15:0] tgt);
    int p1;
    int off;
    p1  = (int'(pc) + 1) % 65536;
    off = int'(word[5:0]);
    if (off >= 32) off = off - 64;
    if (f.hlt) return pc;
    if (f.jr) return tgt;
    if (f.jmp || f.jal) return 16'((p1 / 4096) * 4096 + int'(word[11:0]));
    if ((f.beq && f.zero) || (f.bne && !f.zero)) return 16'((p1 + off + 65536) % 65536);
    return 16'(p1);
  endfunction

  function automatic flags_t fl(input bit h, input bit r, input bit j, input bit l,
                                input bit e, input bit n, input bit z);
    return flags_t'({h, r, j, l, e, n, z});
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic driveFlags(input flags_t f, input logic [15:0] tgt);
    hlt = f.hlt; jr = f.jr; jmp = f.jmp; jal = f.jal;
    br_eq = f.beq; br_ne = f.bne; zero = f.zero;
    jr_target = tgt;
  endtask

  task automatic modelReset();
    m_pc = RESET_PC; m_link = 16'h0; m_last = 16'h0;
    m_retired = 0; m_stalls = 0;
    fetch_q.push_back('{RESET_PC, 16'h0, 16'h0});
  endtask

  task automatic doReset(input int cycles);
    rst = 1'b1;
    repeat (cycles) tick();
    modelReset();
    rst = 1'b0;
  endtask

  task automatic waitReq(output bit ok);
    int g = 0;
    while (imem_req !== 1'b1 && g < 20) begin
      tick();
      g++;
    end
    ok = (imem_req === 1'b1);
    if (!ok) reportFail("req_timeout");
  endtask

  // One instruction: fetch with wait states, optional stall with junk flags, then execute.
  task automatic applyStimulus(input logic [15:0] word, input int wait_cyc, input int stall_cyc,
                               input flags_t f, input logic [15:0] tgt);
    bit ok;
    waitReq(ok);
    if (!ok) return;
    repeat (wait_cyc) tick();
    instr_q.push_back(word);
    imem_ready = 1'b1;
    imem_rdata = word;
    tick();
    imem_ready = 1'b0;
    imem_rdata = 16'($urandom);
    repeat (stall_cyc) begin
      stall = 1'b1;
      driveFlags(flags_t'(7'($urandom)), 16'($urandom));
      m_stalls++;
      tick();
    end
    stall = 1'b0;
    driveFlags(f, tgt);
    m_retired++;
    m_last = word;
    if (f.jal) m_link = m_pc + 16'd1;
    if (f.hlt) begin
      halt_q.push_back(m_pc);
    end else begin
      m_pc = modelNext(m_pc, word, f, tgt);
      fetch_q.push_back('{m_pc, m_link, m_last});
    end
    tick();
    driveFlags('0, 16'h0);
  endtask

  task automatic haltIdleAndReset();
    repeat (5) begin
      imem_ready = 1'($urandom);
      tick();
    end
    imem_ready = 1'b0;
    doReset(2);
  endtask

  // Reset lands while a fetch is waiting and ready arrives in that same cycle.
  task automatic resetMidFetch();
    bit ok;
    waitReq(ok);
    if (!ok) return;
    repeat (2) tick();
    rst = 1'b1;
    imem_ready = 1'b1;
    imem_rdata = 16'hBEEF;
    tick();
    imem_ready = 1'b0;
    tick();
    modelReset();
    rst = 1'b0;
  endtask

  // Monitor: pops expectations whenever the DUT starts a fetch, presents an instruction or halts.
  initial begin
    logic       prev_req = 1'b0, prev_valid = 1'b0, prev_halted = 1'b0;
    logic [15:0] cur_addr = 16'h0;
    fetch_exp_t  e;
    logic [15:0] w;
    forever begin
      @(negedge clk);
      if (rst !== 1'b0) begin
        prev_req = 1'b0; prev_valid = 1'b0; prev_halted = 1'b0;
      end else begin
        if (imem_req && !prev_req) begin
          if (fetch_q.size() == 0) reportFail("fetch_unexpected");
          else begin
            e = fetch_q.pop_front();
            cur_addr = e.addr;
            checkOutput("fetch_addr", 32'(imem_addr), 32'(e.addr));
            checkOutput("pc_link", 32'(pc_link), 32'(e.link));
            checkOutput("instr_hold", 32'(instr), 32'(e.instr));
          end
        end else if (imem_req) begin
          checkOutput("addr_stable", 32'(imem_addr), 32'(cur_addr));
        end
        if (instr_valid && !prev_valid) begin
          if (instr_q.size() == 0) reportFail("valid_unexpected");
          else begin
            w = instr_q.pop_front();
            checkOutput("instr", 32'(instr), 32'(w));
            checkOutput("op_code", 32'(op_code), 32'(w[15:12]));
          end
        end
        checkOutput("req_valid_excl", 32'(imem_req & instr_valid), 32'h0);
        if (halted && !prev_halted) begin
          if (halt_q.size() == 0) reportFail("halt_unexpected");
          else checkOutput("halt_pc", 32'(imem_addr), 32'(halt_q.pop_front()));
        end
        if (halted) checkOutput("halt_quiet", 32'({imem_req, instr_valid}), 32'h0);
        prev_req = imem_req; prev_valid = instr_valid; prev_halted = halted;
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    errors++;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    flags_t f;
    $display("[TB] fetch_sequencer bench starting");
    doReset(2);

    for (int i = 0; i < 5; i++)
      applyStimulus({OPC_ALU, 12'($urandom)}, 0, 0, '0, 16'h0);
    applyStimulus({OPC_ALU, 12'($urandom)}, 3, 0, '0, 16'h0);
    for (int i = 6; i < 10; i++)
      applyStimulus({OPC_ALU, 12'($urandom)}, 0, 0, '0, 16'h0);

    applyStimulus({OPC_BEQ, 6'h0, 6'h3D}, 0, 0, fl(0,0,0,0,1,0,1), 16'h0);
    applyStimulus({OPC_ALU, 12'h001}, 0, 0, '0, 16'h0);
    applyStimulus({OPC_ALU, 12'h002}, 1, 0, '0, 16'h0);
    applyStimulus({OPC_BEQ, 6'h0, 6'h3D}, 0, 0, fl(0,0,0,0,1,0,0), 16'h0);
    applyStimulus({OPC_BNE, 6'h0, 6'h05}, 0, 0, fl(0,0,0,0,0,1,0), 16'h0);

    applyStimulus({OPC_JR, 12'h000}, 0, 0, fl(0,1,0,0,0,0,0), 16'h2005);
    applyStimulus({OPC_JAL, 12'h0F0}, 0, 0, fl(0,0,0,1,0,0,0), 16'h0);
    applyStimulus({OPC_JR, 12'h000}, 0, 0, fl(0,1,0,0,0,0,0), 16'h2006);
    applyStimulus({OPC_J, 12'h123}, 0, 0, fl(0,1,1,0,0,0,0), 16'h3000);

    applyStimulus({OPC_ALU, 12'h0AA}, 0, 2, '0, 16'h0);
    applyStimulus({OPC_HLT, 12'h000}, 0, 0, fl(1,0,0,0,0,0,0), 16'h0);
    haltIdleAndReset();

    applyStimulus({OPC_JR, 12'h000}, 0, 0, fl(0,1,0,0,0,0,0), 16'hFFFF);
    applyStimulus({OPC_ALU, 12'h055}, 1, 0, '0, 16'h0);
    resetMidFetch();

    for (int i = 0; i < 60; i++) begin
      f.hlt  = ($urandom_range(0, 19) == 0);
      f.jr   = ($urandom_range(0, 7) == 0);
      f.jmp  = ($urandom_range(0, 7) == 0);
      f.jal  = ($urandom_range(0, 7) == 0);
      f.beq  = ($urandom_range(0, 3) == 0);
      f.bne  = ($urandom_range(0, 3) == 0);
      f.zero = 1'($urandom);
      applyStimulus(16'($urandom), $urandom_range(0, 3),
                    ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0,
                    f, 16'($urandom));
      if (f.hlt) haltIdleAndReset();
    end

    repeat (3) tick();
`ifdef FETCH_PERF_CNT_EN
    checkOutput("retired_cnt", retired_cnt, 32'(m_retired));
    checkOutput("stall_cnt", stall_cnt, 32'(m_stalls));
`endif
    checkOutput("fetch_q_drained", 32'(fetch_q.size()), 32'h0);
    checkOutput("instr_q_drained", 32'(instr_q.size()), 32'h0);
    checkOutput("halt_q_drained", 32'(halt_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
